pong_score_keeper: RTL and testbench

- Consumes the ball block's score1/score2 outputs and keeps the match score.
- Runs the game-flow FSM: idle, serve delay, play and game over.
- Drives the ball block's reset so the ball re-serves from the origin after each point.
- Shows both scores on the Basys 3 four-digit seven-segment display.

---
 rtl/pong_score_keeper.sv | 231 +++++++++++++++++++++++
 tb/tb_pong_score_keeper.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_keeper
//  Description : Match score keeper and game-flow controller for Pong.
//                Counts points reported by the ball block, sequences
//                idle / serve delay / play / game over, holds the ball in
//                reset between rallies and scans both scores onto the
//                Basys 3 four-digit seven-segment display.
//  Ports       :
//    clk         in   100 MHz system clock
//    reset       in   asynchronous, active-high reset
//    start       in   debounced start button (level, clk-synchronous)
//    score1/2    in   point conditions from the ball block (level)
//    x, y        in   VGA pixel position; x=0,y=481 marks one frame tick
//    ball_reset  out  holds the ball block in reset outside PLAY
//    p1_score    out  player 1 score, packed BCD {tens,ones}
//    p2_score    out  player 2 score, packed BCD {tens,ones}
//    game_over   out  high while in GAMEOVER
//    winner      out  2'b00 none, 2'b01 player 1, 2'b10 player 2
//    an          out  digit anodes, active-low
//    seg         out  segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module pong_score_keeper #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 120,
  parameter int SCAN_W       = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       score1,
  input  logic       score2,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       ball_reset,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    PLAY     = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  localparam int             FC_W       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [FC_W-1:0] SERVE_LAST = FC_W'(SERVE_FRAMES - 1);
  // Scores are kept in BCD, so the win threshold is compared in BCD too.
  localparam logic [7:0]     WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  state_t            state, state_n;
  logic [FC_W-1:0]   frame_cnt, frame_cnt_n;
  logic [7:0]        p1_n, p2_n;
  logic [1:0]        winner_n;
  logic              score1_q, score2_q, start_q;
  logic              s1_rise, s2_rise, st_rise;
  logic              frame_tick;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        sel;
  logic [3:0]        digit;
  logic              blank;
  logic [3:0]        an_n;
  logic [6:0]        seg_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign frame_tick = (y == 10'd481) && (x == 10'd0);
  assign s1_rise    = score1 & ~score1_q;
  assign s2_rise    = score2 & ~score2_q;
  assign st_rise    = start  & ~start_q;

  // Next-state / next-score logic
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    p1_n        = p1_score;
    p2_n        = p2_score;
    winner_n    = winner;
    case (state)
      IDLE: begin
        if (st_rise) begin
          state_n     = SERVE;
          frame_cnt_n = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) begin
            state_n     = PLAY;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        // Player 1 has priority when both sides rise in the same cycle.
        if (s1_rise) begin
          p1_n        = bcd_inc(p1_score);
          frame_cnt_n = '0;
          if (p1_n == WIN_BCD) begin
            state_n  = GAMEOVER;
            winner_n = 2'b01;
          end else begin
            state_n  = SERVE;
          end
        end else if (s2_rise) begin
          p2_n        = bcd_inc(p2_score);
          frame_cnt_n = '0;
          if (p2_n == WIN_BCD) begin
            state_n  = GAMEOVER;
            winner_n = 2'b10;
          end else begin
            state_n  = SERVE;
          end
        end
      end
      GAMEOVER: begin
        if (st_rise) begin
          state_n     = SERVE;
          frame_cnt_n = '0;
          p1_n        = 8'h00;
          p2_n        = 8'h00;
          winner_n    = 2'b00;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and score registers; ball_reset/game_over follow the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      p1_score   <= 8'h00;
      p2_score   <= 8'h00;
      winner     <= 2'b00;
      ball_reset <= 1'b1;
      game_over  <= 1'b0;
      score1_q   <= 1'b0;
      score2_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state      <= state_n;
      frame_cnt  <= frame_cnt_n;
      p1_score   <= p1_n;
      p2_score   <= p2_n;
      winner     <= winner_n;
      ball_reset <= (state_n != PLAY);
      game_over  <= (state_n == GAMEOVER);
      score1_q   <= score1;
      score2_q   <= score2;
      start_q    <= start;
    end
  end

  // Display digit select; a zero tens digit is blanked but its anode stays on.
  assign sel = scan_cnt[SCAN_W-1 -: 2];

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    an_n  = 4'hF;
    case (sel)
      2'd3: begin
        digit = p1_score[7:4];
        blank = (p1_score[7:4] == 4'd0);
        an_n  = 4'b0111;
      end
      2'd2: begin
        digit = p1_score[3:0];
        an_n  = 4'b1011;
      end
      2'd1: begin
        digit = p2_score[7:4];
        blank = (p2_score[7:4] == 4'd0);
        an_n  = 4'b1101;
      end
      default: begin
        digit = p2_score[3:0];
        an_n  = 4'b1110;
      end
    endcase
    seg_n = blank ? 7'h7F : seg_decode(digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      an       <= 4'hF;
      seg      <= 7'h7F;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      an       <= an_n;
      seg      <= seg_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_score_keeper
//  Description : Self-checking bench for pong_score_keeper. A table of
//                point events with hand-computed scores drives the match,
//                with directed sequences around serve timing, display scan,
//                game over and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pong_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       score1 = 1'b0;
  logic       score2 = 1'b0;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       ball_reset;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] an;
  logic [6:0] seg;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       s1;
    logic       s2;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       go;
    logic [1:0] win;
  } vec_t;

  vec_t vecs[20];

  pong_score_keeper #(
    .WIN_SCORE   (11),
    .SERVE_FRAMES(120),
    .SCAN_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .score1    (score1),
    .score2    (score2),
    .x         (x),
    .y         (y),
    .ball_reset(ball_reset),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .game_over (game_over),
    .winner    (winner),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick followed by one idle cycle.
  task automatic frame();
    y = 10'd481;
    x = 10'd0;
    step();
    y = 10'd0;
    step();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic apply_point(input vec_t v);
    score1 = v.s1;
    score2 = v.s2;
    step();
    score1 = 1'b0;
    score2 = 1'b0;
    step();
    check("pt_p1", p1_score, v.p1);
    check("pt_p2", p2_score, v.p2);
    check("pt_game_over", game_over, v.go);
    check("pt_winner", winner, v.win);
    check("pt_ball_reset_after_point", ball_reset, 1'b1);
    if (!v.go) begin
      frames(120);
      check("pt_ball_reset_after_serve", ball_reset, 1'b0);
    end
  endtask

  // Scans the display long enough to visit every digit and checks each
  // anode against the segment pattern expected for p1=02, p2=10.
  task automatic check_display();
    logic [3:0] seen = 4'h0;
    for (int c = 0; c < 40; c++) begin
      step();
      case (an)
        4'b0111: begin seen[3] = 1'b1; check("disp_p1_tens_blank", seg, 7'h7F); end
        4'b1011: begin seen[2] = 1'b1; check("disp_p1_ones_2",     seg, 7'h24); end
        4'b1101: begin seen[1] = 1'b1; check("disp_p2_tens_1",     seg, 7'h79); end
        4'b1110: begin seen[0] = 1'b1; check("disp_p2_ones_0",     seg, 7'h40); end
        default: check("disp_anode_valid", an, 4'b1110);
      endcase
    end
    check("disp_all_digits_seen", seen, 4'hF);
  endtask

  initial begin
    // Point table: {score1, score2, expected p1, p2, game_over, winner}
    vecs[0]  = '{1'b1, 1'b1, 8'h02, 8'h00, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 8'h01, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 8'h02, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 8'h02, 8'h03, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 8'h02, 8'h04, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 8'h02, 8'h05, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 8'h02, 8'h06, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 1'b1, 8'h02, 8'h07, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 8'h02, 8'h08, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 8'h09, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 1'b1, 8'h02, 8'h10, 1'b0, 2'b00};
    vecs[11] = '{1'b1, 1'b0, 8'h03, 8'h10, 1'b0, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 8'h04, 8'h10, 1'b0, 2'b00};
    vecs[13] = '{1'b1, 1'b0, 8'h05, 8'h10, 1'b0, 2'b00};
    vecs[14] = '{1'b1, 1'b0, 8'h06, 8'h10, 1'b0, 2'b00};
    vecs[15] = '{1'b1, 1'b0, 8'h07, 8'h10, 1'b0, 2'b00};
    vecs[16] = '{1'b1, 1'b0, 8'h08, 8'h10, 1'b0, 2'b00};
    vecs[17] = '{1'b1, 1'b0, 8'h09, 8'h10, 1'b0, 2'b00};
    vecs[18] = '{1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 2'b00};
    vecs[19] = '{1'b1, 1'b0, 8'h11, 8'h10, 1'b1, 2'b01};

    // Reset state
    step();
    check("rst_ball_reset", ball_reset, 1'b1);
    check("rst_p1", p1_score, 8'h00);
    check("rst_p2", p2_score, 8'h00);
    check("rst_game_over", game_over, 1'b0);
    check("rst_winner", winner, 2'b00);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    step();
    reset = 1'b0;
    step();
    check("idle_ball_reset", ball_reset, 1'b1);

    // Score rise in IDLE is ignored
    score1 = 1'b1;
    step();
    score1 = 1'b0;
    step();
    check("idle_score_ignored", p1_score, 8'h00);

    // Start -> SERVE, 120 frame ticks -> PLAY
    pulse_start();
    check("serve_ball_reset", ball_reset, 1'b1);
    frames(119);
    check("serve_119_still_held", ball_reset, 1'b1);
    frame();
    check("serve_120_play", ball_reset, 1'b0);
    check("play_p1_zero", p1_score, 8'h00);
    check("play_p2_zero", p2_score, 8'h00);

    // Start ignored in PLAY
    pulse_start();
    check("play_start_ignored", ball_reset, 1'b0);

    // score1 held high across 5 frames counts once
    score1 = 1'b1;
    step();
    check("hold_p1_once", p1_score, 8'h01);
    check("hold_ball_reset", ball_reset, 1'b1);
    frames(5);
    score1 = 1'b0;
    frames(114);
    check("hold_119_still_held", ball_reset, 1'b1);
    check("hold_p1_still_once", p1_score, 8'h01);
    frame();
    check("hold_120_play", ball_reset, 1'b0);
    check("hold_p1_final", p1_score, 8'h01);

    // Table-driven points up to p2 = 10, then the display
    for (int i = 0; i <= 10; i++) apply_point(vecs[i]);
    check_display();
    for (int i = 11; i < 20; i++) apply_point(vecs[i]);

    // GAMEOVER: further rises ignored, frame ticks do not leave
    score1 = 1'b1;
    step();
    score1 = 1'b0;
    step();
    check("go_p1_hold", p1_score, 8'h11);
    check("go_winner_hold", winner, 2'b01);
    frames(3);
    check("go_game_over", game_over, 1'b1);
    check("go_ball_reset", ball_reset, 1'b1);

    // Start from GAMEOVER clears and serves
    pulse_start();
    check("restart_p1", p1_score, 8'h00);
    check("restart_p2", p2_score, 8'h00);
    check("restart_winner", winner, 2'b00);
    check("restart_game_over", game_over, 1'b0);
    check("restart_ball_reset", ball_reset, 1'b1);

    // Start during SERVE must not restart the serve delay
    frames(60);
    pulse_start();
    frames(59);
    check("serve_start_ignored_119", ball_reset, 1'b1);
    frame();
    check("serve_start_ignored_120", ball_reset, 1'b0);

    // Point for p2, then asynchronous reset mid-SERVE at 60 frames
    score2 = 1'b1;
    step();
    score2 = 1'b0;
    step();
    check("p2_point", p2_score, 8'h01);
    frames(60);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_ball_reset", ball_reset, 1'b1);
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_p2_lost", p2_score, 8'h00);
    check("async_game_over", game_over, 1'b0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    frames(119);
    check("post_rst_119_held", ball_reset, 1'b1);
    frame();
    check("post_rst_120_play", ball_reset, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
